defunnel_ctrl: RTL and testbench

- Sequencer for the 4-input/8-slot defunnel datapath (narrow chunk = 8 complex16 samples = 128 b, wide word = 8 chunks = 1024 b).
- Owns the datapath's `t_cfg_dat` (mode/reduct) and per-slot `enable` strobes.
- Accepts narrow beats carrying 1, 2 or 4 chunks over a valid/ready handshake, steers each beat into the next free slots, and raises a wide-word valid once all 8 slots are filled.
- Holds off the narrow side while a completed wide word is unconsumed.

---
 rtl/defunnel_ctrl.sv | 102 ++++++++++
 tb/tb_defunnel_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/defunnel_ctrl.sv
// Sequencer for the defunnel datapath: steers narrow beats into wide-word slots
// and owns the datapath config (reduct) and per-slot capture strobes.
module defunnel_ctrl #(
  parameter int unsigned SLOTS    = 8,
  parameter int unsigned MAXLANES = 4,
  parameter int unsigned CFGW     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               cfg_reduct,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     flush,
  input  logic                     t_valid,
  output logic                     t_ready,
  output logic                     i_valid,
  input  logic                     i_ready,
  output logic [CFGW-1:0]          t_cfg_dat,
  output logic [SLOTS-1:0]         enable,
  output logic [$clog2(SLOTS)-1:0] ptr,
  output logic                     cfg_err
);

  localparam int unsigned PTRW = $clog2(SLOTS);
  localparam int unsigned SUMW = PTRW + 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]      state, nextState;
  logic [2:0]      reduct, nextReduct;
  logic [PTRW-1:0] ptrQ, nextPtr;
  logic            errQ, nextErr;

  logic            isFill;
  logic            atZero;
  logic            cfgLegal;
  logic            cfgGrant;
  logic            tReadyC;
  logic            tAccept;
  logic [SUMW-1:0] ptrSum;
  logic [SLOTS-1:0] laneMask;
  logic [SLOTS-1:0] enableC;

  // Handshake arbitration, slot strobes and next-state
  always_comb begin
    nextState  = state;
    nextReduct = reduct;
    nextPtr    = ptrQ;
    nextErr    = errQ;

    isFill   = (state == FILL);
    atZero   = (ptrQ == '0);
    cfgLegal = ((cfg_reduct == 3'd1) || (cfg_reduct == 3'd2) || (cfg_reduct == 3'd4))
               && (32'(cfg_reduct) <= MAXLANES);
    // Flush only matters while filling; a completed word is never discarded.
    cfgGrant = cfg_valid && atZero && (isFill ? !flush : i_ready);
    // A pending config at a word boundary takes the slot ahead of data.
    tReadyC  = (isFill ? !flush : i_ready) && !(cfg_valid && atZero);
    tAccept  = t_valid && tReadyC;

    laneMask = SLOTS'((32'd1 << reduct) - 32'd1);
    enableC  = tAccept ? SLOTS'(laneMask << ptrQ) : '0;
    ptrSum   = SUMW'(ptrQ) + SUMW'(reduct);

    if (isFill && flush) begin
      nextPtr = '0;
    end else if (cfgGrant) begin
      if (cfgLegal) nextReduct = cfg_reduct;
      else          nextErr    = 1'b1;
      nextState = FILL;
    end else if (tAccept) begin
      nextPtr   = PTRW'(ptrSum);
      nextState = (ptrSum == SUMW'(SLOTS)) ? FULL : FILL;
    end else if (!isFill && i_ready) begin
      nextState = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FILL;
      reduct <= 3'd1;
      ptrQ   <= '0;
      errQ   <= 1'b0;
    end else begin
      state  <= nextState;
      reduct <= nextReduct;
      ptrQ   <= nextPtr;
      errQ   <= nextErr;
    end
  end

  assign cfg_ready = cfgGrant;
  assign t_ready   = tReadyC;
  assign enable    = enableC;
  assign i_valid   = (state == FULL);
  assign t_cfg_dat = CFGW'(reduct);
  assign ptr       = ptrQ;
  assign cfg_err   = errQ;

endmodule

// File: tb/tb_defunnel_ctrl.sv
// Directed self-checking bench for defunnel_ctrl; inputs change on negedge,
// combinational outputs are sampled 1 time unit later, registered ones after each edge.
module tb_defunnel_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cfg_reduct;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       flush;
  logic       t_valid;
  logic       t_ready;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] t_cfg_dat;
  logic [7:0] enable;
  logic [2:0] ptr;
  logic       cfg_err;

  int passCnt = 0;
  int checkCnt = 0;

  defunnel_ctrl #(.SLOTS(8), .MAXLANES(4), .CFGW(8)) dut (
    .clk(clk), .reset(reset), .cfg_reduct(cfg_reduct), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .flush(flush), .t_valid(t_valid), .t_ready(t_ready),
    .i_valid(i_valid), .i_ready(i_ready), .t_cfg_dat(t_cfg_dat), .enable(enable),
    .ptr(ptr), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1; cfg_valid = 1'b0; cfg_reduct = 3'd1; flush = 1'b0;
    t_valid = 1'b0; i_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic grantCfg(input logic [2:0] r);
    cfg_valid = 1'b1; cfg_reduct = r;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    checkCnt++; if (ptr !== 3'd0) $display("FAIL reset_ptr: got %0d expected 0", ptr); else passCnt++;
    checkCnt++; if (i_valid !== 1'b0) $display("FAIL reset_ivalid: got %b expected 0", i_valid); else passCnt++;
    checkCnt++; if (cfg_err !== 1'b0) $display("FAIL reset_cfgerr: got %b expected 0", cfg_err); else passCnt++;
    checkCnt++; if (t_cfg_dat !== 8'h01) $display("FAIL reset_cfgdat: got %h expected 01", t_cfg_dat); else passCnt++;
    checkCnt++; if (enable !== 8'h00) $display("FAIL reset_enable: got %h expected 00", enable); else passCnt++;
    checkCnt++; if (t_ready !== 1'b1) $display("FAIL reset_tready: got %b expected 1", t_ready); else passCnt++;
    checkCnt++; if (cfg_ready !== 1'b0) $display("FAIL reset_cfgready: got %b expected 0", cfg_ready); else passCnt++;
  endtask

  task automatic test_reduct1();
    logic [7:0] exp;
    doReset();
    i_ready = 1'b1; t_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = 8'(1 << i);
      #1;
      checkCnt++; if (enable !== exp) $display("FAIL r1_enable beat %0d: got %h expected %h", i, enable, exp); else passCnt++;
      checkCnt++; if (ptr !== 3'(i)) $display("FAIL r1_ptr beat %0d: got %0d expected %0d", i, ptr, i); else passCnt++;
      checkCnt++; if (i_valid !== 1'b0) $display("FAIL r1_ivalid_fill beat %0d: got %b expected 0", i, i_valid); else passCnt++;
      tick();
    end
    #1;
    checkCnt++; if (i_valid !== 1'b1) $display("FAIL r1_ivalid_full: got %b expected 1", i_valid); else passCnt++;
    checkCnt++; if (t_ready !== 1'b1) $display("FAIL r1_b2b_tready: got %b expected 1", t_ready); else passCnt++;
    checkCnt++; if (enable !== 8'h01) $display("FAIL r1_b2b_enable: got %h expected 01", enable); else passCnt++;
    tick();
    t_valid = 1'b0;
    checkCnt++; if (i_valid !== 1'b0) $display("FAIL r1_after_b2b_ivalid: got %b expected 0", i_valid); else passCnt++;
    checkCnt++; if (ptr !== 3'd1) $display("FAIL r1_after_b2b_ptr: got %0d expected 1", ptr); else passCnt++;
  endtask

  task automatic test_cfg4();
    doReset();
    cfg_valid = 1'b1; cfg_reduct = 3'd4; t_valid = 1'b1;
    #1;
    checkCnt++; if (cfg_ready !== 1'b1) $display("FAIL c4_cfgready: got %b expected 1", cfg_ready); else passCnt++;
    checkCnt++; if (t_ready !== 1'b0) $display("FAIL c4_cfg_wins_tready: got %b expected 0", t_ready); else passCnt++;
    checkCnt++; if (enable !== 8'h00) $display("FAIL c4_cfg_wins_enable: got %h expected 00", enable); else passCnt++;
    tick();
    cfg_valid = 1'b0;
    checkCnt++; if (t_cfg_dat !== 8'h04) $display("FAIL c4_cfgdat: got %h expected 04", t_cfg_dat); else passCnt++;
    #1;
    checkCnt++; if (enable !== 8'h0F) $display("FAIL c4_enable0: got %h expected 0F", enable); else passCnt++;
    tick();
    #1;
    checkCnt++; if (enable !== 8'hF0) $display("FAIL c4_enable1: got %h expected F0", enable); else passCnt++;
    tick();
    t_valid = 1'b0;
    checkCnt++; if (i_valid !== 1'b1) $display("FAIL c4_ivalid: got %b expected 1", i_valid); else passCnt++;
    checkCnt++; if (ptr !== 3'd0) $display("FAIL c4_ptr_wrap: got %0d expected 0", ptr); else passCnt++;
  endtask

  task automatic test_backpressure();
    doReset();
    grantCfg(3'd2);
    i_ready = 1'b0; t_valid = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checkCnt++; if (t_ready !== 1'b0) $display("FAIL bp_tready cyc %0d: got %b expected 0", i, t_ready); else passCnt++;
      checkCnt++; if (enable !== 8'h00) $display("FAIL bp_enable cyc %0d: got %h expected 00", i, enable); else passCnt++;
      checkCnt++; if (i_valid !== 1'b1) $display("FAIL bp_ivalid cyc %0d: got %b expected 1", i, i_valid); else passCnt++;
      tick();
    end
    i_ready = 1'b1;
    #1;
    checkCnt++; if (t_ready !== 1'b1) $display("FAIL bp_release_tready: got %b expected 1", t_ready); else passCnt++;
    checkCnt++; if (enable !== 8'h03) $display("FAIL bp_release_enable: got %h expected 03", enable); else passCnt++;
    tick();
    t_valid = 1'b0;
    checkCnt++; if (i_valid !== 1'b0) $display("FAIL bp_after_ivalid: got %b expected 0", i_valid); else passCnt++;
    checkCnt++; if (ptr !== 3'd2) $display("FAIL bp_after_ptr: got %0d expected 2", ptr); else passCnt++;
  endtask

  task automatic test_cfg_blocked();
    doReset();
    grantCfg(3'd2);
    t_valid = 1'b1;
    repeat (2) tick();
    t_valid = 1'b0;
    checkCnt++; if (ptr !== 3'd4) $display("FAIL cb_ptr_mid: got %0d expected 4", ptr); else passCnt++;
    cfg_valid = 1'b1; cfg_reduct = 3'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkCnt++; if (cfg_ready !== 1'b0) $display("FAIL cb_cfgready_mid cyc %0d: got %b expected 0", i, cfg_ready); else passCnt++;
      tick();
    end
    flush = 1'b1;
    #1;
    checkCnt++; if (t_ready !== 1'b0) $display("FAIL cb_flush_tready: got %b expected 0", t_ready); else passCnt++;
    tick();
    flush = 1'b0;
    checkCnt++; if (ptr !== 3'd0) $display("FAIL cb_flush_ptr: got %0d expected 0", ptr); else passCnt++;
    checkCnt++; if (t_cfg_dat !== 8'h02) $display("FAIL cb_cfgdat_held: got %h expected 02", t_cfg_dat); else passCnt++;
    #1;
    checkCnt++; if (cfg_ready !== 1'b1) $display("FAIL cb_cfgready_after: got %b expected 1", cfg_ready); else passCnt++;
    tick();
    cfg_valid = 1'b0;
    checkCnt++; if (t_cfg_dat !== 8'h04) $display("FAIL cb_cfgdat_new: got %h expected 04", t_cfg_dat); else passCnt++;
  endtask

  task automatic test_cfg_err();
    doReset();
    cfg_valid = 1'b1; cfg_reduct = 3'd3;
    #1;
    checkCnt++; if (cfg_ready !== 1'b1) $display("FAIL ce_cfgready: got %b expected 1", cfg_ready); else passCnt++;
    tick();
    cfg_valid = 1'b0;
    checkCnt++; if (cfg_err !== 1'b1) $display("FAIL ce_err_set: got %b expected 1", cfg_err); else passCnt++;
    checkCnt++; if (t_cfg_dat !== 8'h01) $display("FAIL ce_cfgdat_kept: got %h expected 01", t_cfg_dat); else passCnt++;
    grantCfg(3'd2);
    tick();
    checkCnt++; if (cfg_err !== 1'b1) $display("FAIL ce_err_sticky: got %b expected 1", cfg_err); else passCnt++;
    checkCnt++; if (t_cfg_dat !== 8'h02) $display("FAIL ce_cfgdat_legal: got %h expected 02", t_cfg_dat); else passCnt++;
    doReset();
    checkCnt++; if (cfg_err !== 1'b0) $display("FAIL ce_err_reset: got %b expected 0", cfg_err); else passCnt++;
  endtask

  task automatic test_flush_priority();
    doReset();
    t_valid = 1'b1;
    tick();
    flush = 1'b1; cfg_valid = 1'b1; cfg_reduct = 3'd4;
    #1;
    checkCnt++; if (enable !== 8'h00) $display("FAIL fp1_enable: got %h expected 00", enable); else passCnt++;
    checkCnt++; if (t_ready !== 1'b0) $display("FAIL fp1_tready: got %b expected 0", t_ready); else passCnt++;
    tick();
    checkCnt++; if (ptr !== 3'd0) $display("FAIL fp1_ptr: got %0d expected 0", ptr); else passCnt++;
    #1;
    checkCnt++; if (cfg_ready !== 1'b0) $display("FAIL fp0_cfgready: got %b expected 0", cfg_ready); else passCnt++;
    checkCnt++; if (enable !== 8'h00) $display("FAIL fp0_enable: got %h expected 00", enable); else passCnt++;
    tick();
    flush = 1'b0; cfg_valid = 1'b0; t_valid = 1'b0;
    checkCnt++; if (t_cfg_dat !== 8'h01) $display("FAIL fp0_cfgdat: got %h expected 01", t_cfg_dat); else passCnt++;
    checkCnt++; if (ptr !== 3'd0) $display("FAIL fp0_ptr: got %0d expected 0", ptr); else passCnt++;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_reduct = 3'd1; flush = 1'b0;
    t_valid = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_reduct1();
    test_cfg4();
    test_backpressure();
    test_cfg_blocked();
    test_cfg_err();
    test_flush_priority();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
